// File: rtl/wb_arb_rr.sv
// Three-master round-robin Wishbone arbiter onto one shared slave port.
// The grant is held for the whole master cycle; a stalled slave is cut off by a response timeout.
module wb_arb_rr #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [2:0]        m_cyc_i,
  input  logic [2:0]        m_stb_i,
  input  logic [2:0]        m_we_i,
  input  logic [3*DW/8-1:0] m_sel_i,
  input  logic [3*AW-1:0]   m_adr_i,
  input  logic [3*DW-1:0]   m_dat_i,
  output logic [DW-1:0]     m_dat_o,
  output logic [2:0]        m_ack_o,
  output logic [2:0]        m_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [2:0]        grant_o,
  output logic              to_evt_o
);

  localparam int SW = DW / 8;
  localparam logic [9:0] TO_LAST = 10'(TO_CYC - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     r_state;
  logic [2:0] r_grant;
  logic [1:0] r_last;
  logic [9:0] r_cnt;
  logic       r_to;

  logic [1:0] w_gidx;
  logic [2:0] w_pick;
  logic       w_busy;
  logic       w_to;
  logic       w_cnt_inc;

  // Index of the granted master, derived from the one-hot grant
  always_comb begin
    case (r_grant)
      3'b001:  w_gidx = 2'd0;
      3'b010:  w_gidx = 2'd1;
      3'b100:  w_gidx = 2'd2;
      default: w_gidx = 2'd0;
    endcase
  end

  // Round-robin pick, searching upward from the master after the last one served
  always_comb begin
    w_pick = 3'b000;
    case (r_last)
      2'd0: begin
        if (m_cyc_i[1])      w_pick = 3'b010;
        else if (m_cyc_i[2]) w_pick = 3'b100;
        else if (m_cyc_i[0]) w_pick = 3'b001;
        else                 w_pick = 3'b000;
      end
      2'd1: begin
        if (m_cyc_i[2])      w_pick = 3'b100;
        else if (m_cyc_i[0]) w_pick = 3'b001;
        else if (m_cyc_i[1]) w_pick = 3'b010;
        else                 w_pick = 3'b000;
      end
      default: begin
        if (m_cyc_i[0])      w_pick = 3'b001;
        else if (m_cyc_i[1]) w_pick = 3'b010;
        else if (m_cyc_i[2]) w_pick = 3'b100;
        else                 w_pick = 3'b000;
      end
    endcase
  end

  // Gating with the reset drops the slave cycle at once when reset hits mid-transfer
  assign w_busy = (r_state == BUSY) && !wb_rst_i;

  assign s_cyc_o = w_busy & m_cyc_i[w_gidx];
  assign s_stb_o = w_busy & m_stb_i[w_gidx] & ~r_to;
  assign s_we_o  = w_busy & m_we_i[w_gidx];
  assign s_sel_o = w_busy ? m_sel_i[w_gidx*SW +: SW] : {SW{1'b0}};
  assign s_adr_o = w_busy ? m_adr_i[w_gidx*AW +: AW] : {AW{1'b0}};
  assign s_dat_o = w_busy ? m_dat_i[w_gidx*DW +: DW] : {DW{1'b0}};

  assign m_dat_o = s_dat_i;

  // A late ack in the timeout cycle still completes the transfer normally
  assign w_to      = w_busy & r_to & ~s_ack_i;
  assign m_ack_o   = (w_busy & s_ack_i) ? r_grant : 3'b000;
  assign m_err_o   = (w_busy & (s_err_i | w_to)) ? r_grant : 3'b000;
  assign to_evt_o  = w_to;
  assign grant_o   = r_grant;
  assign w_cnt_inc = s_stb_o & ~s_ack_i & ~s_err_i;

  // Arbitration FSM with grant, last-served and timeout tracking
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= 3'b000;
      r_last  <= 2'd2;
      r_cnt   <= 10'd0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 10'd0;
          r_to  <= 1'b0;
          if (m_cyc_i != 3'b000) begin
            r_grant <= w_pick;
            r_state <= BUSY;
          end else begin
            r_grant <= 3'b000;
          end
        end
        BUSY: begin
          if (!m_cyc_i[w_gidx]) begin
            r_state <= IDLE;
            r_last  <= w_gidx;
            r_grant <= 3'b000;
            r_cnt   <= 10'd0;
            r_to    <= 1'b0;
          end else if (w_cnt_inc && (r_cnt == TO_LAST)) begin
            r_cnt <= 10'd0;
            r_to  <= 1'b1;
          end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 10'd1;
            r_to  <= 1'b0;
          end else begin
            r_cnt <= 10'd0;
            r_to  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 3'b000;
          r_cnt   <= 10'd0;
          r_to    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Directed self-checking bench for wb_arb_rr with a short timeout (TO_CYC = 8).
module tb_wb_arb_rr;

  logic        clk;
  logic        rst;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [11:0] m_sel;
  logic [95:0] m_adr, m_dat;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_ack, s_err;
  logic [2:0]  grant;
  logic        to_evt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] exp_g [4];

  wb_arb_rr #(.AW(32), .DW(32), .TO_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant), .to_evt_o(to_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = 3'b000; m_stb = 3'b000; m_we = 3'b000;
    m_sel = 12'h000; m_adr = 96'h0; m_dat = 96'h0;
    s_dat_i = 32'h0; s_ack = 1'b0; s_err = 1'b0;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    step();
    step();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_scyc", 64'(s_cyc), 64'h0);
    chk("rst_toevt", 64'(to_evt), 64'h0);
    chk("rst_ackerr", 64'({m_ack, m_err}), 64'h0);
    rst = 1'b0;
    step();

    // Single master write from m1
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
    m_sel[7:4] = 4'hF;
    m_adr[63:32] = 32'h3000_0000;
    m_dat[63:32] = 32'h0000_AB60;
    #1;
    chk("idle_grant", 64'(grant), 64'h0);
    chk("idle_scyc", 64'(s_cyc), 64'h0);
    step();
    chk("m1_grant", 64'(grant), 64'h2);
    chk("m1_adr", 64'(s_adr), 64'h3000_0000);
    chk("m1_dat", 64'(s_dat_o), 64'h0000_AB60);
    chk("m1_ctl", 64'({s_cyc, s_stb, s_we, s_sel}), 64'h7F);
    chk("m1_noack", 64'(m_ack), 64'h0);
    s_ack = 1'b1; s_dat_i = 32'hDEAD_0001;
    #1;
    chk("m1_ack", 64'(m_ack), 64'h2);
    chk("m1_noerr", 64'(m_err), 64'h0);
    chk("mdat_bcast", 64'(m_dat_o), 64'hDEAD_0001);
    step();
    s_ack = 1'b0;
    m_cyc = 3'b000; m_stb = 3'b000; m_we = 3'b000;
    #1;
    chk("m1_drop_scyc", 64'(s_cyc), 64'h0);
    step();
    chk("m1_back_idle", 64'(grant), 64'h0);

    // Fresh reset, then all three request: m0, m1, m2, m0
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cyc = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), 64'(grant), 64'(exp_g[i]));
      m_cyc = 3'b111 & ~exp_g[i];
      step();
      chk($sformatf("rr_idle%0d", i), 64'(grant), 64'h0);
      m_cyc = 3'b111;
    end
    m_cyc = 3'b000;
    step();

    // m0 holds a 4-beat cycle while m2 waits
    m_cyc = 3'b001; m_stb = 3'b001;
    m_adr[31:0] = 32'h0000_0100;
    step();
    chk("hold_grant0", 64'(grant), 64'h1);
    m_cyc = 3'b101; m_stb = 3'b101;
    m_adr[95:64] = 32'h0000_0200;
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("hold_beat%0d", b), 64'({grant, m_ack, s_adr}), {26'h0, 3'b001, 3'b001, 32'h0000_0100});
      step();
    end
    s_ack = 1'b0;
    m_cyc = 3'b100; m_stb = 3'b100;
    step();
    chk("hold_idle", 64'({grant, s_cyc}), 64'h0);
    step();
    chk("hold_grant2", 64'(grant), 64'h4);
    chk("hold_adr2", 64'(s_adr), 64'h0000_0200);
    m_cyc = 3'b000; m_stb = 3'b000;
    step();

    // Slave never answers m1: pulse on the 9th cycle after m_stb rises
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("to_wait%0d", k), 64'({to_evt, m_err, s_stb}), 64'h1);
    end
    step();
    chk("to_pulse", 64'({to_evt, m_err, s_stb}), {59'h0, 1'b1, 3'b010, 1'b0});
    step();
    chk("to_after", 64'({to_evt, m_err, s_stb}), 64'h1);

    // Slave error on a read
    s_err = 1'b1;
    #1;
    chk("serr_err", 64'(m_err), 64'h2);
    chk("serr_noack", 64'(m_ack), 64'h0);
    s_err = 1'b0;
    #1;

    // Reset mid-BUSY takes effect without a clock edge
    rst = 1'b1;
    #1;
    chk("arst_grant", 64'(grant), 64'h0);
    chk("arst_scyc", 64'({s_cyc, s_stb}), 64'h0);
    chk("arst_ackerr", 64'({m_ack, m_err}), 64'h0);
    step();
    rst = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b000;
    step();
    chk("arst_next_m0", 64'(grant), 64'h1);
    m_cyc = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arb_rr.md
WB_ARB_RR -- requirements
Module: wb_arb_rr

Interface
REQ-001 The block SHALL have parameter AW, 32, address width.
REQ-002 The block SHALL have parameter DW, 32, data width.
REQ-003 The block SHALL have parameter TO_CYC, 255, slave-response timeout in wb_clk_i cycles (legal range 2..1023).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports:
  wb_clk_i  in  1  single clock; all state on rising edge
  wb_rst_i  in  1  asynchronous, active-high reset
  m_cyc_i  in  3  per-master cycle request; bit n = master n
  m_stb_i  in  3  per-master strobe
  m_we_i  in  3  per-master write enable
  m_sel_i  in  3*DW/8  per-master byte selects; master n at [n*DW/8 +: DW/8]
  m_adr_i  in  3*AW  per-master address; master n at [n*AW +: AW]
  m_dat_i  in  3*DW  per-master write data
  m_dat_o  out  DW  read data, broadcast to all masters
  m_ack_o  out  3  per-master acknowledge
  m_err_o  out  3  per-master error (slave error or timeout)
  s_cyc_o, s_stb_o, s_we_o  out  1 each  to shared user-project slave port
  s_sel_o  out  DW/8  to slave
  s_adr_o  out  AW  to slave
  s_dat_o  out  DW  to slave
  s_dat_i  in  DW  slave read data
  s_ack_i  in  1  slave acknowledge
  s_err_i  in  1  slave error
  grant_o  out  3  one-hot current grant; 0 when idle
  to_evt_o  out  1  one-cycle pulse on timeout

Function
REQ-005 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-006 In IDLE with m_cyc_i != 0, the block SHALL select a master round-robin, searching from (last+1) mod 3 upward, register grant, and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-007 In IDLE with m_cyc_i == 0, the block SHALL remain in IDLE with grant_o = 0.
REQ-008 In IDLE, all s_* outputs SHALL be 0, and m_ack_o and m_err_o SHALL be 0.
REQ-009 In BUSY, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow the granted master's inputs.
REQ-010 In BUSY, m_ack_o[g] SHALL equal s_ack_i, and all other m_ack_o bits SHALL be 0; m_dat_o SHALL equal s_dat_i at all times.
REQ-011 The grant SHALL be held for as long as the granted m_cyc_i stays high, so multi-beat and locked cycles are never split.
REQ-012 When the granted m_cyc_i goes low, the block SHALL return to IDLE on that edge and set last to g; re-arbitration SHALL occur in IDLE the following cycle.
REQ-013 Requests arriving from other masters during BUSY SHALL wait and SHALL NOT affect s_* outputs.
REQ-014 Timeout counter (10 bits) SHALL increment each cycle with s_stb_o=1, s_ack_i=0, s_err_i=0.
REQ-015 The timeout counter SHALL clear on s_ack_i, on s_err_i, on s_stb_o=0, and in IDLE.
REQ-016 When the counter reaches TO_CYC-1 with no response, on the next cycle m_err_o[g]=1 and to_evt_o=1 for exactly one cycle, and the counter SHALL clear.
REQ-017 During the timeout error cycle, s_stb_o SHALL be forced to 0.
REQ-018 m_err_o[g] SHALL equal s_err_i OR the timeout pulse, and other m_err_o bits SHALL be 0.
REQ-019 If s_ack_i and timeout coincide, ack SHALL win and no error SHALL be issued.

Reset
REQ-020 On wb_rst_i=1 (asynchronous), the block SHALL enter IDLE, set grant_o=0, clear the counter, set to_evt_o=0, and set last=2, so that master 0 has first priority.
REQ-021 A reset asserted mid-BUSY SHALL drop s_cyc_o/s_stb_o immediately, without waiting for a clock edge; no ack or err SHALL be issued for the aborted cycle.
REQ-022 After wb_rst_i deasserts, the first arbitration SHALL occur on the first rising edge with m_cyc_i != 0.

Verification
REQ-023 Single master: m1 writes 0x0000_AB60 to 0x3000_0000 → grant_o=3'b010 one cycle after cyc; s_adr_o=0x3000_0000, s_dat_o=0x0000_AB60; m_ack_o=3'b010 when s_ack_i is asserted.
REQ-024 All three masters request simultaneously after reset → grants in order m0, m1, m2, m0; each is granted once per round.
REQ-025 m0 holds cyc for 4 beats while m2 requests → m2 is not granted until m0 drops cyc; grant_o=3'b100 one cycle after IDLE.
REQ-026 Slave never acks, TO_CYC=8 → m_err_o[g] and to_evt_o pulse exactly once, 9 cycles after stb; s_stb_o=0 in that cycle.
REQ-027 s_err_i returned on a read → m_err_o[g]=1 and m_ack_o=0 in the same cycle; a reset pulse mid-BUSY → grant_o=0 and s_cyc_o=0 without a clock edge, and the next grant goes to m0.
